// File: rtl/mac_dot_product_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: the FSM state encoding
// and the minimum spacing between accumulator command pulses.
package mac_dot_product_sequencer_pkg;

   // Sequencer FSM states.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_RETURN    = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_OUT       = 3'd4
   } seq_state_e;

   // The accumulator needs at least this many cycles between the rising
   // edges of two command pulses (oMAC/oRET), i.e. one idle cycle between them.
   localparam int MIN_PULSE_SPACING = 2;

   // Width of the spacing down-counter, kept at least one bit wide.
   function automatic int gap_width(input int spacing);
      gap_width = (spacing > 2) ? $clog2(spacing) : 1;
   endfunction

endpackage

// File: rtl/mac_dot_product_sequencer_sync_fifo.sv
// Small synchronous FIFO for the operand pairs. The head entry is read
// combinationally so a pair written into an empty FIFO can be popped on
// the very next clock edge.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iPush,
   input  logic [WIDTH-1:0] iData,
   input  logic             iPop,
   output logic [WIDTH-1:0] oData,
   output logic             oFull,
   output logic             oEmpty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign oFull   = (count_q == FULL_COUNT);
   assign oEmpty  = (count_q == '0);
   assign push_ok = iPush && !oFull;
   assign pop_ok  = iPop && !oEmpty;
   assign oData   = mem_q[rd_ptr_q];

   // Next pointer/count values; DEPTH is a power of two so pointers wrap freely.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge iClk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= iData;
      end
   end

endmodule

// File: rtl/mac_dot_product_sequencer.sv
// Master-side driver for a multiply-accumulator: buffers signed operand
// pairs, issues one accumulate pulse per pair, then a return pulse, waits
// for done and offers the captured sum on a valid/ready result port.
module mac_dot_product_sequencer
   import mac_dot_product_sequencer_pkg::*;
#(
   parameter int INPUT_LENGTH  = 16,
   parameter int OUTPUT_LENGTH = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iStart,
   input  logic [LEN_WIDTH-1:0]     iLen,
   input  logic [INPUT_LENGTH-1:0]  iA,
   input  logic [INPUT_LENGTH-1:0]  iB,
   input  logic                     iValid,
   output logic                     oAccept,
   output logic [INPUT_LENGTH-1:0]  oMacA,
   output logic [INPUT_LENGTH-1:0]  oMacB,
   output logic                     oMAC,
   output logic                     oRET,
   input  logic                     iMacReady,
   input  logic                     iMacDone,
   input  logic [OUTPUT_LENGTH-1:0] iMacRes,
   output logic [OUTPUT_LENGTH-1:0] oRes,
   output logic                     oResValid,
   input  logic                     iResReady,
   output logic                     oBusy
);

   localparam int GAP_W = gap_width(MIN_PULSE_SPACING);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_PULSE_SPACING - 1);

   seq_state_e                 state_q, state_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [LEN_WIDTH-1:0]       rcvd_q, rcvd_d;
   logic [LEN_WIDTH-1:0]       issued_q, issued_d;
   logic [GAP_W-1:0]           gap_q, gap_d;
   logic                       mac_q, mac_d;
   logic                       ret_q, ret_d;
   logic [INPUT_LENGTH-1:0]    maca_q, maca_d;
   logic [INPUT_LENGTH-1:0]    macb_q, macb_d;
   logic [OUTPUT_LENGTH-1:0]   res_q, res_d;
   logic                       resvalid_q, resvalid_d;

   logic                       fifo_full;
   logic                       fifo_empty;
   logic [2*INPUT_LENGTH-1:0]  fifo_head;
   logic                       push;
   logic                       issue;
   logic                       gap_ok;

   // Accept only while running, with room, and until len pairs have arrived.
   assign oAccept = (state_q == ST_RUN) && !fifo_full && (rcvd_q < len_q);
   assign push    = iValid && oAccept;

   // Command pulses must be separated by the accumulator's minimum spacing.
   assign gap_ok  = (gap_q == '0);
   assign issue   = (state_q == ST_RUN) && !fifo_empty && (issued_q < len_q)
                    && iMacReady && gap_ok;

   sync_fifo #(
      .WIDTH (2*INPUT_LENGTH),
      .DEPTH (FIFO_DEPTH)
   ) u_pair_fifo (
      .iClk   (iClk),
      .iRst   (iRst),
      .iPush  (push),
      .iData  ({iA, iB}),
      .iPop   (issue),
      .oData  (fifo_head),
      .oFull  (fifo_full),
      .oEmpty (fifo_empty)
   );

   assign oMAC      = mac_q;
   assign oRET      = ret_q;
   assign oMacA     = maca_q;
   assign oMacB     = macb_q;
   assign oRes      = res_q;
   assign oResValid = resvalid_q;
   assign oBusy     = (state_q != ST_IDLE);

   // Next-state logic for the FSM, counters, pulses and result capture.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      rcvd_d     = push  ? (rcvd_q + LEN_WIDTH'(1))   : rcvd_q;
      issued_d   = issue ? (issued_q + LEN_WIDTH'(1)) : issued_q;
      mac_d      = issue;
      ret_d      = 1'b0;
      maca_d     = issue ? fifo_head[2*INPUT_LENGTH-1:INPUT_LENGTH] : maca_q;
      macb_d     = issue ? fifo_head[INPUT_LENGTH-1:0]              : macb_q;
      res_d      = res_q;
      resvalid_d = resvalid_q;

      // A pulse reloads the spacing counter; otherwise it drains to zero.
      if (issue) begin
         gap_d = GAP_RELOAD;
      end else if (gap_q != '0) begin
         gap_d = gap_q - GAP_W'(1);
      end else begin
         gap_d = gap_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               len_d    = iLen;
               rcvd_d   = '0;
               issued_d = '0;
               state_d  = (iLen == '0) ? ST_RETURN : ST_RUN;
            end
         end
         ST_RUN: begin
            // All pairs issued: the last oMAC is high during this cycle.
            if (issued_q == len_q) begin
               state_d = ST_RETURN;
            end
         end
         ST_RETURN: begin
            if (iMacReady && gap_ok && !mac_q) begin
               ret_d   = 1'b1;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (iMacDone) begin
               res_d      = iMacRes;
               resvalid_d = 1'b1;
               state_d    = ST_OUT;
            end
         end
         ST_OUT: begin
            if (iResReady) begin
               resvalid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any operation immediately.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         rcvd_q     <= '0;
         issued_q   <= '0;
         gap_q      <= '0;
         mac_q      <= 1'b0;
         ret_q      <= 1'b0;
         maca_q     <= '0;
         macb_q     <= '0;
         res_q      <= '0;
         resvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         rcvd_q     <= rcvd_d;
         issued_q   <= issued_d;
         gap_q      <= gap_d;
         mac_q      <= mac_d;
         ret_q      <= ret_d;
         maca_q     <= maca_d;
         macb_q     <= macb_d;
         res_q      <= res_d;
         resvalid_q <= resvalid_d;
      end
   end

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// Directed bench for the dot-product sequencer with a behavioural
// multiply-accumulator model attached to its accumulator port.
module tb_mac_dot_product_sequencer;

   logic        clk;
   logic        iRst;
   logic        iStart;
   logic [7:0]  iLen;
   logic [15:0] iA, iB;
   logic        iValid;
   logic        oAccept;
   logic [15:0] oMacA, oMacB;
   logic        oMAC, oRET;
   logic        iMacReady;
   logic        iMacDone;
   logic [31:0] iMacRes;
   logic [31:0] oRes;
   logic        oResValid;
   logic        iResReady;
   logic        oBusy;

   int vectors = 0;
   int miscompares = 0;

   // Accumulator model and monitors
   int          acc;
   logic        ret_pending;
   int          mac_cnt, ret_cnt, spacing_err, both_err, resvalid_cycles;
   logic        accept_seen;
   int          cyc, last_mac_cyc;
   logic [15:0] issued_a[$];

   // Operand source
   logic [15:0] src_a[$];
   logic [15:0] src_b[$];
   int          src_idx;
   logic        will_push;

   mac_dot_product_sequencer dut (
      .iClk      (clk),
      .iRst      (iRst),
      .iStart    (iStart),
      .iLen      (iLen),
      .iA        (iA),
      .iB        (iB),
      .iValid    (iValid),
      .oAccept   (oAccept),
      .oMacA     (oMacA),
      .oMacB     (oMacB),
      .oMAC      (oMAC),
      .oRET      (oRET),
      .iMacReady (iMacReady),
      .iMacDone  (iMacDone),
      .iMacRes   (iMacRes),
      .oRes      (oRes),
      .oResValid (oResValid),
      .iResReady (iResReady),
      .oBusy     (oBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      acc = 0; ret_pending = 1'b0; iMacDone = 1'b0; iMacRes = '0;
      mac_cnt = 0; ret_cnt = 0; spacing_err = 0; both_err = 0; resvalid_cycles = 0;
      accept_seen = 1'b0; last_mac_cyc = -100;
      issued_a.delete(); src_a.delete(); src_b.delete();
      src_idx = 0; will_push = 1'b0; iValid = 1'b0; iA = '0; iB = '0;
   endtask

   task automatic add_pair(input int a, input int b);
      src_a.push_back(16'(a));
      src_b.push_back(16'(b));
   endtask

   // One clock cycle: observe at the falling edge, run the accumulator model,
   // then drive the source for the next rising edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (oMAC) begin
         mac_cnt++;
         if (cyc - last_mac_cyc < 2) spacing_err++;
         last_mac_cyc = cyc;
         acc = acc + int'($signed(oMacA)) * int'($signed(oMacB));
         issued_a.push_back(oMacA);
      end
      if (oRET) ret_cnt++;
      if (oMAC && oRET) both_err++;
      if (oAccept) accept_seen = 1'b1;
      if (oResValid) resvalid_cycles++;
      if (iMacDone) begin
         iMacDone = 1'b0;
         acc = 0;
      end
      if (ret_pending) begin
         iMacDone = 1'b1;
         iMacRes = 32'(acc);
         ret_pending = 1'b0;
      end
      if (oRET) ret_pending = 1'b1;
      if (will_push) src_idx++;
      if (src_idx < src_a.size()) begin
         iValid = 1'b1; iA = src_a[src_idx]; iB = src_b[src_idx];
      end else begin
         iValid = 1'b0;
      end
      will_push = iValid && oAccept;
   endtask

   task automatic start(input int len);
      iLen = 8'(len);
      iStart = 1'b1;
      step();
      iStart = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!oResValid && n < budget) begin
         step();
         n++;
      end
      check(tag, {31'd0, oResValid}, 32'd1);
   endtask

   initial begin
      iRst = 1'b0; iStart = 1'b0; iLen = '0; iMacReady = 1'b1; iResReady = 1'b1;
      cyc = 0;
      clear_stats();
      #1;
      check("rst_accept", {31'd0, oAccept}, 32'd0);
      check("rst_mac", {31'd0, oMAC}, 32'd0);
      check("rst_ret", {31'd0, oRET}, 32'd0);
      check("rst_maca", {16'd0, oMacA}, 32'd0);
      check("rst_macb", {16'd0, oMacB}, 32'd0);
      check("rst_res", oRes, 32'd0);
      check("rst_resvalid", {31'd0, oResValid}, 32'd0);
      check("rst_busy", {31'd0, oBusy}, 32'd0);
      step(); step();
      iRst = 1'b1;
      step();

      // Basic vector: 2*3 + (-4)*5 + 7*(-1) = -21
      clear_stats();
      add_pair(2, 3); add_pair(-4, 5); add_pair(7, -1);
      start(3);
      check("basic_busy", {31'd0, oBusy}, 32'd1);
      wait_valid("basic_valid", 80);
      check("basic_res", oRes, 32'hFFFF_FFEB);
      step();
      check("basic_valid_clr", {31'd0, oResValid}, 32'd0);
      check("basic_idle", {31'd0, oBusy}, 32'd0);
      check("basic_valid_len", 32'(resvalid_cycles), 32'd1);
      check("basic_mac_cnt", 32'(mac_cnt), 32'd3);
      check("basic_ret_cnt", 32'(ret_cnt), 32'd1);
      check("basic_spacing", 32'(spacing_err), 32'd0);

      // Zero length: no accumulate pulses, one return, result 0
      clear_stats();
      start(0);
      wait_valid("len0_valid", 40);
      check("len0_res", oRes, 32'd0);
      step();
      check("len0_mac_cnt", 32'(mac_cnt), 32'd0);
      check("len0_accept", {31'd0, accept_seen}, 32'd0);
      check("len0_ret_cnt", 32'(ret_cnt), 32'd1);

      // Backpressure: accumulator not ready for 20 cycles
      clear_stats();
      iMacReady = 1'b0;
      add_pair(1, 2); add_pair(-2, 2); add_pair(3, 2); add_pair(-4, 2);
      add_pair(5, 2); add_pair(-6, 2); add_pair(7, 2); add_pair(-8, 2);
      start(8);
      for (int i = 0; i < 20; i++) step();
      check("bp_pushed", 32'(src_idx), 32'd4);
      check("bp_accept_low", {31'd0, oAccept}, 32'd0);
      check("bp_no_mac", 32'(mac_cnt), 32'd0);
      iMacReady = 1'b1;
      wait_valid("bp_valid", 200);
      check("bp_res", oRes, 32'hFFFF_FFF8);
      check("bp_mac_cnt", 32'(mac_cnt), 32'd8);
      check("bp_spacing", 32'(spacing_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (i < issued_a.size())
            check($sformatf("bp_order%0d", i), {16'd0, issued_a[i]}, {16'd0, src_a[i]});
         else
            check($sformatf("bp_order%0d", i), 32'hDEAD_BEEF, {16'd0, src_a[i]});
      end
      step();

      // Excess operands: only the first two of four are taken
      clear_stats();
      add_pair(1, 1); add_pair(2, 2); add_pair(3, 3); add_pair(4, 4);
      start(2);
      wait_valid("ex_valid", 80);
      check("ex_res", oRes, 32'd5);
      check("ex_accepted", 32'(src_idx), 32'd2);
      check("ex_accept_low", {31'd0, oAccept}, 32'd0);
      step();

      // Result hold with iStart pulses ignored in OUT
      clear_stats();
      iResReady = 1'b0;
      add_pair(3, 4);
      start(1);
      wait_valid("hold_valid", 60);
      for (int i = 0; i < 10; i++) begin
         iStart = (i % 2 == 0); iLen = 8'd5;
         step();
         check("hold_res", oRes, 32'd12);
         check("hold_valid_hi", {31'd0, oResValid}, 32'd1);
         check("hold_busy", {31'd0, oBusy}, 32'd1);
      end
      iStart = 1'b0;
      iResReady = 1'b1;
      step();
      check("hold_release_valid", {31'd0, oResValid}, 32'd0);
      check("hold_release_idle", {31'd0, oBusy}, 32'd0);
      check("hold_res_kept", oRes, 32'd12);
      step();
      check("hold_stays_idle", {31'd0, oBusy}, 32'd0);

      // Reset in the middle of a run, after two of five issues
      clear_stats();
      for (int i = 0; i < 5; i++) add_pair(2, 2);
      start(5);
      for (int n = 0; n < 60 && mac_cnt < 2; n++) step();
      check("mid_mac_cnt", 32'(mac_cnt), 32'd2);
      #2 iRst = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
      check("mid_rst_accept", {31'd0, oAccept}, 32'd0);
      check("mid_rst_mac", {31'd0, oMAC}, 32'd0);
      check("mid_rst_ret", {31'd0, oRET}, 32'd0);
      check("mid_rst_maca", {16'd0, oMacA}, 32'd0);
      check("mid_rst_res", oRes, 32'd0);
      check("mid_rst_resvalid", {31'd0, oResValid}, 32'd0);
      clear_stats();
      step();
      iRst = 1'b1;
      step();

      // Fresh run after reset: (-1)*(-1) = 1
      clear_stats();
      add_pair(-1, -1);
      start(1);
      wait_valid("fresh_valid", 60);
      check("fresh_res", oRes, 32'd1);
      check("fresh_mac_cnt", 32'(mac_cnt), 32'd1);
      step();
      check("fresh_idle", {31'd0, oBusy}, 32'd0);
      check("never_mac_and_ret", 32'(both_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
